// File: rtl/dac_buffer_pkg.sv
// Shared types and default sizing for the DAC stream buffer.
package dac_buffer_pkg;

  localparam int unsigned DefDataW = 256;
  localparam int unsigned DefDepth = 8;
  localparam int unsigned DefCntW  = 16;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StRun
  } state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with registered occupancy and flush.
module sync_fifo #(
  parameter int unsigned DataW = 256,
  parameter int unsigned Depth = 8,
  parameter int unsigned LvlW  = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             wr_i,
  input  logic [DataW-1:0] wdata_i,
  input  logic             rd_i,
  output logic [DataW-1:0] rdata_o,
  output logic [LvlW-1:0]  level_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [DataW-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]  level_q, level_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q + LvlW'(wr_i) - LvlW'(rd_i);
    if (wr_i) begin
      wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
    end
    if (rd_i) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
    end
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is never cleared; the level alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (wr_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;
  assign full_o  = (level_q == LvlW'(Depth));
  assign empty_o = (level_q == '0);

endmodule

// File: rtl/dac_stream_buffer.sv
// Elastic buffer between tx_core and the RF DAC: prefills to a threshold, then streams,
// feeding silence whenever it has nothing to send and counting underflows.
module dac_stream_buffer
  import dac_buffer_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned DEPTH  = DefDepth,
  parameter int unsigned CNT_W  = DefCntW
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              enable,
  input  logic [3:0]        fill_threshold,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tvalid,
  output logic              s_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic [3:0]        level,
  output logic [CNT_W-1:0]  underflow_count
);

  localparam int unsigned LvlW = 4;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  ucnt_q, ucnt_d;
  logic [LvlW-1:0]   eff_thr;
  logic              wr_en, rd_en, flush, full, empty;
  logic [DATA_W-1:0] head;

  sync_fifo #(
    .DataW (DATA_W),
    .Depth (DEPTH),
    .LvlW  (LvlW)
  ) u_fifo (
    .clk_i   (clock),
    .rst_ni  (resetn),
    .flush_i (flush),
    .wr_i    (wr_en),
    .wdata_i (s_tdata),
    .rd_i    (rd_en),
    .rdata_o (head),
    .level_o (level),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    if (fill_threshold == '0) begin
      eff_thr = LvlW'(1);
    end else if (fill_threshold > LvlW'(DEPTH)) begin
      eff_thr = LvlW'(DEPTH);
    end else begin
      eff_thr = fill_threshold;
    end
  end

  always_comb begin
    state_d  = state_q;
    ucnt_d   = ucnt_q;
    s_tready = 1'b0;
    m_tvalid = 1'b0;
    m_tdata  = '0;
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    flush    = 1'b0;
    unique case (state_q)
      StIdle: begin
        flush = 1'b1;
        if (enable) state_d = StFill;
      end
      StFill: begin
        s_tready = !full;
        m_tvalid = 1'b1;
        wr_en    = s_tvalid && !full;
        if (level >= eff_thr) state_d = StRun;
      end
      StRun: begin
        s_tready = !full;
        m_tvalid = 1'b1;
        wr_en    = s_tvalid && !full;
        if (!empty) begin
          m_tdata = head;
          rd_en   = m_tready;
        end else if (m_tready) begin
          // DAC consumed a silence word it should have had data for.
          if (ucnt_q != '1) ucnt_d = ucnt_q + CNT_W'(1);
          state_d = StFill;
        end
      end
      default: state_d = StIdle;
    endcase
    if (!enable) begin
      state_d = StIdle;
      flush   = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= StIdle;
      ucnt_q  <= '0;
    end else begin
      state_q <= state_d;
      ucnt_q  <= ucnt_d;
    end
  end

  assign underflow_count = ucnt_q;

endmodule

// File: tb/tb_dac_stream_buffer.sv
// Directed bench for dac_stream_buffer with a queue-based reference model checked every cycle.
module tb_dac_stream_buffer;

  localparam int DW    = 64;
  localparam int DEPTH = 8;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;
  localparam int MIdle = 0;
  localparam int MFill = 1;
  localparam int MRun  = 2;

  logic          clock;
  logic          resetn;
  logic          enable;
  logic [3:0]    fill_threshold;
  logic [DW-1:0] s_tdata;
  logic          s_tvalid;
  logic          s_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready;
  logic [3:0]    level;
  logic [CW-1:0] underflow_count;

  int checks = 0;
  int errors = 0;

  dac_stream_buffer #(
    .DATA_W (DW),
    .DEPTH  (DEPTH),
    .CNT_W  (CW)
  ) dut (
    .clock           (clock),
    .resetn          (resetn),
    .enable          (enable),
    .fill_threshold  (fill_threshold),
    .s_tdata         (s_tdata),
    .s_tvalid        (s_tvalid),
    .s_tready        (s_tready),
    .m_tdata         (m_tdata),
    .m_tvalid        (m_tvalid),
    .m_tready        (m_tready),
    .level           (level),
    .underflow_count (underflow_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int eff_thr(input int t);
    if (t == 0) return 1;
    if (t > DEPTH) return DEPTH;
    return t;
  endfunction

  // Reference model: mode, a queue of buffered words and an underflow tally.
  int            mmode = MIdle;
  logic [DW-1:0] mq[$];
  int            mcnt = 0;
  bit            known = 1'b0;
  logic [DW-1:0] popped[$];

  initial begin
    forever begin
      @(negedge clock);
      if (known) begin
        logic [DW-1:0] exp_data;
        exp_data = '0;
        if (mmode == MRun && mq.size() > 0) exp_data = mq[0];
        chk("cyc_s_tready", 64'(s_tready), 64'(mmode != MIdle && mq.size() < DEPTH));
        chk("cyc_m_tvalid", 64'(m_tvalid), 64'(mmode != MIdle));
        chk("cyc_m_tdata", 64'(m_tdata), 64'(exp_data));
        chk("cyc_level", 64'(level), 64'(mq.size()));
        chk("cyc_underflow", 64'(underflow_count), 64'(mcnt));
      end
      // Inputs are stable here until the next rising edge, so step the model now.
      begin
        int lvl;
        bit wr;
        lvl = mq.size();
        wr  = (mmode != MIdle) && (lvl < DEPTH) && (s_tvalid === 1'b1);
        if (resetn !== 1'b1) begin
          mmode = MIdle;
          mq.delete();
          mcnt  = 0;
          known = 1'b1;
        end else if (enable !== 1'b1) begin
          mmode = MIdle;
          mq.delete();
        end else begin
          case (mmode)
            MIdle: mmode = MFill;
            MFill: if (lvl >= eff_thr(int'(fill_threshold))) mmode = MRun;
            default: begin
              if (lvl > 0 && m_tready) begin
                popped.push_back(m_tdata);
                void'(mq.pop_front());
              end else if (lvl == 0 && m_tready) begin
                if (mcnt < CMAX) mcnt++;
                mmode = MFill;
              end
            end
          endcase
          if (wr) mq.push_back(s_tdata);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic push(input logic [DW-1:0] w);
    bit done;
    bit rdy;
    done     = 1'b0;
    s_tvalid = 1'b1;
    s_tdata  = w;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clock);
      rdy = s_tready;
      @(posedge clock);
      #1;
      if (rdy) done = 1'b1;
    end
    s_tvalid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL push_timeout got no s_tready want handshake for %0h", w);
    end
  endtask

  task automatic flush_buf();
    enable = 1'b0;
    tick(1);
    chk("lit_flush_level", 64'(level), 64'd0);
    chk("lit_flush_mvalid", 64'(m_tvalid), 64'd0);
    enable = 1'b1;
    tick(1);
  endtask

  initial begin
    int saved;
    resetn = 1'b0; enable = 1'b0; fill_threshold = 4'd4;
    s_tvalid = 1'b0; s_tdata = '0; m_tready = 1'b0;
    tick(3);
    chk("lit_rst_level", 64'(level), 64'd0);
    chk("lit_rst_mvalid", 64'(m_tvalid), 64'd0);
    chk("lit_rst_sready", 64'(s_tready), 64'd0);
    chk("lit_rst_mdata", 64'(m_tdata), 64'd0);
    chk("lit_rst_count", 64'(underflow_count), 64'd0);

    // Prefill to 4, stream A..D, then one underflow.
    resetn = 1'b1; enable = 1'b1; m_tready = 1'b1;
    tick(1);
    push(64'hA0); push(64'hA1); push(64'hA2); push(64'hA3);
    tick(12);
    chk("lit_abcd_n", 64'(popped.size()), 64'd4);
    for (int i = 0; i < 4 && i < popped.size(); i++) chk("lit_abcd", popped[i], 64'hA0 + 64'(i));
    chk("lit_uf_one", 64'(underflow_count), 64'd1);
    chk("lit_uf_level", 64'(level), 64'd0);

    // After underflow, a lone word waits for the threshold again.
    popped.delete();
    push(64'hE0);
    tick(3);
    chk("lit_wait_mdata", 64'(m_tdata), 64'd0);
    chk("lit_wait_level", 64'(level), 64'd1);
    push(64'hE1); push(64'hE2); push(64'hE3);
    tick(10);
    chk("lit_efgh_n", 64'(popped.size()), 64'd4);
    for (int i = 0; i < 4 && i < popped.size(); i++) chk("lit_efgh", popped[i], 64'hE0 + 64'(i));
    chk("lit_uf_two", 64'(underflow_count), 64'd2);

    // Backpressure: fill to DEPTH, hold a ninth word, then release.
    flush_buf();
    popped.delete();
    m_tready = 1'b0;
    for (int i = 0; i < 8; i++) push(64'hB0 + 64'(i));
    s_tvalid = 1'b1; s_tdata = 64'hB8;
    tick(3);
    chk("lit_full_sready", 64'(s_tready), 64'd0);
    chk("lit_full_level", 64'(level), 64'd8);
    m_tready = 1'b1;
    push(64'hB8); push(64'hB9);
    tick(14);
    chk("lit_bp_n", 64'(popped.size()), 64'd10);
    for (int i = 0; i < 10 && i < popped.size(); i++) chk("lit_bp", popped[i], 64'hB0 + 64'(i));
    chk("lit_uf_three", 64'(underflow_count), 64'd3);

    // Continuous read and write across several pointer wraps.
    flush_buf();
    popped.delete();
    for (int i = 0; i < 24; i++) begin
      push(64'hC00 + 64'(i));
      if (i == 11) chk("lit_steady_level", 64'(level), 64'd5);
    end
    tick(10);
    chk("lit_stream_n", 64'(popped.size()), 64'd24);
    for (int i = 0; i < 24 && i < popped.size(); i++) chk("lit_stream", popped[i], 64'hC00 + 64'(i));
    chk("lit_uf_four", 64'(underflow_count), 64'd4);

    // Disable with 5 words held; threshold 15 clamps to DEPTH.
    flush_buf();
    fill_threshold = 4'd15;
    for (int i = 0; i < 5; i++) push(64'hD0 + 64'(i));
    chk("lit_hold5_level", 64'(level), 64'd5);
    saved = int'(underflow_count);
    enable = 1'b0;
    tick(1);
    chk("lit_dis_level", 64'(level), 64'd0);
    chk("lit_dis_mvalid", 64'(m_tvalid), 64'd0);
    chk("lit_dis_sready", 64'(s_tready), 64'd0);
    chk("lit_dis_count", 64'(underflow_count), 64'(saved));
    enable = 1'b1;
    tick(1);
    for (int i = 0; i < 7; i++) push(64'hF0 + 64'(i));
    tick(2);
    chk("lit_thr15_level7", 64'(level), 64'd7);
    chk("lit_thr15_mdata7", 64'(m_tdata), 64'd0);
    push(64'hF7);
    tick(1);
    chk("lit_thr15_run", 64'(m_tdata), 64'hF0);
    chk("lit_thr15_level8", 64'(level), 64'd8);
    tick(12);

    // Threshold 0 behaves as 1.
    flush_buf();
    fill_threshold = 4'd0;
    push(64'h5A);
    tick(1);
    chk("lit_thr0_mdata", 64'(m_tdata), 64'h5A);
    chk("lit_thr0_level", 64'(level), 64'd1);
    tick(4);
    chk("lit_uf_six", 64'(underflow_count), 64'd6);

    // Reset in RUN drops buffered words and the counter.
    flush_buf();
    fill_threshold = 4'd4;
    m_tready = 1'b0;
    for (int i = 0; i < 5; i++) push(64'h70 + 64'(i));
    tick(2);
    resetn = 1'b0;
    tick(1);
    chk("lit_midrst_level", 64'(level), 64'd0);
    chk("lit_midrst_count", 64'(underflow_count), 64'd0);
    chk("lit_midrst_mvalid", 64'(m_tvalid), 64'd0);
    chk("lit_midrst_mdata", 64'(m_tdata), 64'd0);
    resetn = 1'b1;
    tick(1);

    // Saturation: more than 2^CW underflows.
    fill_threshold = 4'd0;
    m_tready = 1'b1;
    for (int i = 0; i < CMAX + 4; i++) begin
      push(64'h900 + 64'(i));
      tick(4);
    end
    chk("lit_sat", 64'(underflow_count), 64'(CMAX));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dac_stream_buffer.md
DAC_STREAM_BUFFER -- requirements
Module: dac_stream_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 256, stream word width (16 x 16-bit DAC samples).
REQ-002 SHALL have parameter DEPTH, default 8, FIFO depth in words (power of two).
REQ-003 SHALL have parameter CNT_W, default 16, underflow counter width.
REQ-004 SHALL have port clock  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port enable  input  1  1 = buffer active, 0 = flush and idle.
REQ-007 SHALL have port fill_threshold  input  4  words required before streaming starts.
REQ-008 SHALL have ports s_tdata/s_tvalid/s_tready  in/in/out  DATA_W/1/1  upstream stream from tx_core dac_tdata/dac_tvalid/dac_tready.
REQ-009 SHALL have ports m_tdata/m_tvalid/m_tready  out/out/in  DATA_W/1/1  stream to RF DAC.
REQ-010 SHALL have port level  output  4  current FIFO occupancy, 0..DEPTH.
REQ-011 SHALL have port underflow_count  output  CNT_W  saturating count of underflow events.

Function
REQ-012 SHALL implement FSM states IDLE, FILL, RUN.
REQ-013 IDLE: s_tready=0, m_tvalid=0, m_tdata=0; FIFO pointers and level held at 0.
REQ-014 IDLE -> FILL on the cycle after enable=1 is sampled.
REQ-015 Any state -> IDLE on the cycle after enable=0 is sampled; FIFO contents discarded; underflow_count retained.
REQ-016 FILL/RUN: s_tready = (level < DEPTH); write occurs when s_tvalid & s_tready.
REQ-017 FILL: m_tvalid=1, m_tdata=0 (DAC fed silence); no reads.
REQ-018 FILL -> RUN when level >= effective threshold; effective threshold = 1 if fill_threshold=0, DEPTH if fill_threshold>DEPTH, else fill_threshold.
REQ-019 RUN: m_tvalid=1; if level>0, m_tdata = FIFO head (first-word-fall-through), popped when m_tready=1.
REQ-020 RUN with level=0 and m_tready=1: m_tdata=0, underflow_count += 1 (saturate at all-ones), next state FILL.
REQ-021 RUN with level=0 and m_tready=0: m_tdata=0, no count, remain RUN.
REQ-022 Write latency: word accepted in cycle n SHALL be visible on m_tdata no earlier than cycle n+1; no write-to-read bypass.
REQ-023 Simultaneous read and write: level unchanged; both pointers advance modulo DEPTH.
REQ-024 Simultaneous write and underflow (RUN, level=0): write accepted, underflow counted, state -> FILL, level=1 next cycle.
REQ-025 Words SHALL leave in arrival order; no loss or duplication; pointers wrap DEPTH-1 -> 0.
REQ-026 level output SHALL be registered and equal writes minus reads since last flush.

Reset
REQ-027 resetn=0 at a clock edge SHALL force state=IDLE, pointers=0, level=0, underflow_count=0.
REQ-028 During and after reset until exit from IDLE: s_tready=0, m_tvalid=0, m_tdata=0.
REQ-029 Reset asserted mid-RUN SHALL discard buffered words; FIFO memory contents need not be cleared.

Structure
REQ-030 Package dac_buffer_pkg SHALL hold the state enum (IDLE/FILL/RUN) and DATA_W/DEPTH/CNT_W defaults.
REQ-031 FIFO storage and pointer/level logic SHALL be a sub-module sync_fifo; FSM and counter in dac_stream_buffer.

Verification
REQ-032 Reset then enable=1, threshold=4, write 4 words A..D, m_tready=1 -> zeros during FILL, then A,B,C,D consecutively, level returns to 0.
REQ-033 RUN, upstream stalls with level=0 and m_tready=1 -> m_tdata=0, underflow_count increments by exactly 1, state FILL, next words wait for threshold.
REQ-034 m_tready=0, write 10 words -> s_tready drops after 8, level=8, then release m_tready -> first 8 words in order, words 9-10 follow.
REQ-035 Continuous simultaneous read/write over 20 words -> level constant, pointer wrap, output sequence equals input sequence.
REQ-036 enable=0 with level=5 -> IDLE next cycle, m_tvalid=0, level=0, underflow_count unchanged; fill_threshold=0 and 15 -> RUN entry at level 1 and 8.
REQ-037 Force 2^CNT_W+3 underflows -> underflow_count holds all-ones.
